alu_flag_unit: RTL and testbench

ALU_FLAG_UNIT -- requirements
Module: alu_flag_unit

---
 rtl/alu_flag_unit.sv | 112 +++++++++++
 tb/tb_alu_flag_unit.sv | 134 +++++++++++++
 2 files changed

// File: rtl/alu_flag_unit.sv
// Single-cycle ALU with registered result, live carry/zero flags and an
// interrupt shadow copy of those flags (save on entry, restore on return).
module alu_flag_unit #(
  parameter int WIDTH       = 8,
  parameter bit ZERO_ON_MOV = 1'b0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             OP_VALID,
  input  logic [3:0]       SEL,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             FLG_C_SET,
  input  logic             FLG_C_CLR,
  input  logic             FLG_SAVE,
  input  logic             FLG_RESTORE,
  output logic [WIDTH-1:0] RESULT,
  output logic             RES_VALID,
  output logic             C,
  output logic             Z,
  output logic             SHAD_C,
  output logic             SHAD_Z
);

  typedef enum logic [3:0] {
    OP_ADD  = 4'h0, OP_ADDC = 4'h1, OP_SUB  = 4'h2, OP_SUBC = 4'h3,
    OP_CMP  = 4'h4, OP_AND  = 4'h5, OP_OR   = 4'h6, OP_XOR  = 4'h7,
    OP_TEST = 4'h8, OP_LSL  = 4'h9, OP_LSR  = 4'hA, OP_ROL  = 4'hB,
    OP_ROR  = 4'hC, OP_ASR  = 4'hD, OP_MOV  = 4'hE, OP_NOP  = 4'hF
  } op_e;

  typedef struct packed {
    logic [WIDTH-1:0] res;
    logic             c;
    logic             wr_res;
    logic             wr_c;
    logic             wr_z;
  } alu_out_t;

  logic [WIDTH:0]   arith;
  logic [WIDTH:0]   cin_ext;
  alu_out_t         alu;
  logic             z_new;

  assign cin_ext = {{WIDTH{1'b0}}, C};

  always_comb begin
    arith      = '0;
    alu.res    = '0;
    alu.c      = 1'b0;
    alu.wr_res = 1'b1;
    alu.wr_c   = 1'b1;
    alu.wr_z   = 1'b1;
    unique case (op_e'(SEL))
      OP_ADD:  arith = {1'b0, A} + {1'b0, B};
      OP_ADDC: arith = {1'b0, A} + {1'b0, B} + cin_ext;
      OP_SUB:  arith = {1'b0, A} - {1'b0, B};
      OP_SUBC: arith = {1'b0, A} - {1'b0, B} - cin_ext;
      OP_CMP:  begin arith = {1'b0, A} - {1'b0, B}; alu.wr_res = 1'b0; end
      default: arith = '0;
    endcase
    // the arithmetic top bit is carry for adds and borrow for subtracts
    alu.res = arith[WIDTH-1:0];
    alu.c   = arith[WIDTH];
    unique case (op_e'(SEL))
      OP_AND:  begin alu.res = A & B; alu.c = 1'b0; end
      OP_OR:   begin alu.res = A | B; alu.c = 1'b0; end
      OP_XOR:  begin alu.res = A ^ B; alu.c = 1'b0; end
      OP_TEST: begin alu.res = A & B; alu.c = 1'b0; alu.wr_res = 1'b0; end
      OP_LSL:  begin alu.res = {A[WIDTH-2:0], C};        alu.c = A[WIDTH-1]; end
      OP_LSR:  begin alu.res = {C, A[WIDTH-1:1]};        alu.c = A[0];       end
      OP_ROL:  begin alu.res = {A[WIDTH-2:0], A[WIDTH-1]}; alu.c = A[WIDTH-1]; end
      OP_ROR:  begin alu.res = {A[0], A[WIDTH-1:1]};     alu.c = A[0];       end
      OP_ASR:  begin alu.res = {A[WIDTH-1], A[WIDTH-1:1]}; alu.c = A[0];     end
      OP_MOV:  begin alu.res = B; alu.wr_c = 1'b0; alu.wr_z = ZERO_ON_MOV; end
      OP_NOP:  begin alu.wr_res = 1'b0; alu.wr_c = 1'b0; alu.wr_z = 1'b0; end
      default: ;
    endcase
  end

  assign z_new = (alu.res == '0);

  always_ff @(posedge CLK) begin
    if (RST) begin
      RESULT    <= '0;
      RES_VALID <= 1'b0;
      C         <= 1'b0;
      Z         <= 1'b0;
      SHAD_C    <= 1'b0;
      SHAD_Z    <= 1'b0;
    end else begin
      RES_VALID <= OP_VALID;
      if (OP_VALID && alu.wr_res) RESULT <= alu.res;
      // save beats restore; both beat the op's own flag result
      if (FLG_SAVE) begin
        SHAD_C <= C;
        SHAD_Z <= Z;
        C      <= 1'b0;
        Z      <= 1'b0;
      end else if (FLG_RESTORE) begin
        C <= SHAD_C;
        Z <= SHAD_Z;
      end else begin
        if (OP_VALID && alu.wr_c) C <= alu.c;
        else if (FLG_C_SET)       C <= 1'b1;
        else if (FLG_C_CLR)       C <= 1'b0;
        if (OP_VALID && alu.wr_z) Z <= z_new;
      end
    end
  end

endmodule

// File: tb/tb_alu_flag_unit.sv
// Directed bench for alu_flag_unit: 8-bit instance for the main flow, 16-bit
// instance for the wide carry/zero case.
module tb_alu_flag_unit;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic       rst = 1'b1, op_valid = 1'b0, c_set = 1'b0, c_clr = 1'b0;
  logic       save = 1'b0, restore = 1'b0;
  logic [3:0] sel = 4'hF;
  logic [7:0] a = '0, b = '0;
  logic [7:0] result;
  logic       res_valid, c, z, shad_c, shad_z;

  logic        op_valid16 = 1'b0;
  logic [3:0]  sel16 = 4'hF;
  logic [15:0] a16 = '0, b16 = '0;
  logic [15:0] result16;
  logic        res_valid16, c16, z16, shad_c16, shad_z16;

  alu_flag_unit #(.WIDTH(8)) dut8 (
    .CLK(clk), .RST(rst), .OP_VALID(op_valid), .SEL(sel), .A(a), .B(b),
    .FLG_C_SET(c_set), .FLG_C_CLR(c_clr), .FLG_SAVE(save), .FLG_RESTORE(restore),
    .RESULT(result), .RES_VALID(res_valid), .C(c), .Z(z),
    .SHAD_C(shad_c), .SHAD_Z(shad_z));

  alu_flag_unit #(.WIDTH(16)) dut16 (
    .CLK(clk), .RST(rst), .OP_VALID(op_valid16), .SEL(sel16), .A(a16), .B(b16),
    .FLG_C_SET(1'b0), .FLG_C_CLR(1'b0), .FLG_SAVE(1'b0), .FLG_RESTORE(1'b0),
    .RESULT(result16), .RES_VALID(res_valid16), .C(c16), .Z(z16),
    .SHAD_C(shad_c16), .SHAD_Z(shad_z16));

  // one clock with the given op; controls drop back to idle afterwards
  task automatic step(input logic v, input logic [3:0] s, input logic [7:0] ia, input logic [7:0] ib);
    op_valid = v; sel = s; a = ia; b = ib;
    @(posedge clk); #1;
    op_valid = 1'b0; c_set = 1'b0; c_clr = 1'b0; save = 1'b0; restore = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    step(1'b1, 4'h0, 8'hFF, 8'h01);
    rst = 1'b0;
    checks++; if (result !== 8'h00) begin failures++; $display("FAIL reset_result got=%h exp=00", result); end
    checks++; if (res_valid !== 1'b0) begin failures++; $display("FAIL reset_rv got=%b exp=0", res_valid); end
    checks++; if ({c, z, shad_c, shad_z} !== 4'b0000) begin failures++; $display("FAIL reset_flags got=%b exp=0000", {c, z, shad_c, shad_z}); end
    checks++; if ({result16, res_valid16, c16, z16, shad_c16, shad_z16} !== 21'd0) begin failures++; $display("FAIL reset16 got=%h exp=0", {result16, res_valid16, c16, z16}); end
  endtask

  task automatic test_add;
    step(1'b1, 4'h0, 8'hFF, 8'h01);
    checks++; if (result !== 8'h00) begin failures++; $display("FAIL add_result got=%h exp=00", result); end
    checks++; if ({res_valid, c, z} !== 3'b111) begin failures++; $display("FAIL add_rv_c_z got=%b exp=111", {res_valid, c, z}); end
    step(1'b0, 4'h0, 8'h00, 8'h00);
    checks++; if (res_valid !== 1'b0) begin failures++; $display("FAIL add_rv_pulse got=%b exp=0", res_valid); end
  endtask

  task automatic test_carry_chain;
    c_clr = 1'b1; step(1'b0, 4'hF, 8'h00, 8'h00);
    checks++; if (c !== 1'b0) begin failures++; $display("FAIL c_clr got=%b exp=0", c); end
    c_set = 1'b1; step(1'b0, 4'hF, 8'h00, 8'h00);
    checks++; if (c !== 1'b1) begin failures++; $display("FAIL c_set got=%b exp=1", c); end
    step(1'b1, 4'h1, 8'h10, 8'h20);
    checks++; if ({result, c, z} !== {8'h31, 2'b00}) begin failures++; $display("FAIL addc got=%h/%b%b exp=31/00", result, c, z); end
    step(1'b1, 4'h4, 8'h03, 8'h07);
    checks++; if ({result, c, z, res_valid} !== {8'h31, 3'b101}) begin failures++; $display("FAIL cmp got=%h/%b%b%b exp=31/101", result, c, z, res_valid); end
    c_clr = 1'b1; step(1'b0, 4'hF, 8'h00, 8'h00);
    step(1'b1, 4'h3, 8'h05, 8'h05);
    checks++; if ({result, c, z} !== {8'h00, 2'b01}) begin failures++; $display("FAIL subc got=%h/%b%b exp=00/01", result, c, z); end
  endtask

  task automatic test_save_restore;
    step(1'b1, 4'h0, 8'hF0, 8'h20);
    checks++; if ({result, c, z} !== {8'h10, 2'b10}) begin failures++; $display("FAIL pre_save got=%h/%b%b exp=10/10", result, c, z); end
    save = 1'b1; step(1'b1, 4'h0, 8'h00, 8'h00);
    checks++; if ({result, res_valid, c, z, shad_c, shad_z} !== {8'h00, 5'b10010}) begin failures++; $display("FAIL save got=%h/%b exp=00/10010", result, {res_valid, c, z, shad_c, shad_z}); end
    restore = 1'b1; step(1'b0, 4'hF, 8'h00, 8'h00);
    checks++; if ({c, z, shad_c, shad_z} !== 4'b1010) begin failures++; $display("FAIL restore got=%b exp=1010", {c, z, shad_c, shad_z}); end
    restore = 1'b1; step(1'b0, 4'hF, 8'h00, 8'h00);
    checks++; if ({c, z, shad_c, shad_z} !== 4'b1010) begin failures++; $display("FAIL restore_again got=%b exp=1010", {c, z, shad_c, shad_z}); end
    step(1'b1, 4'h1, 8'h00, 8'h00);
    checks++; if ({result, c, z} !== {8'h01, 2'b00}) begin failures++; $display("FAIL addc_after_restore got=%h/%b%b exp=01/00", result, c, z); end
  endtask

  task automatic test_shifts;
    step(1'b1, 4'hD, 8'h81, 8'h00);
    checks++; if ({result, c} !== {8'hC0, 1'b1}) begin failures++; $display("FAIL asr got=%h/%b exp=c0/1", result, c); end
    step(1'b1, 4'hB, 8'h80, 8'h00);
    checks++; if ({result, c} !== {8'h01, 1'b1}) begin failures++; $display("FAIL rol got=%h/%b exp=01/1", result, c); end
    step(1'b1, 4'hA, 8'h02, 8'h00);
    checks++; if ({result, c, z} !== {8'h81, 2'b00}) begin failures++; $display("FAIL lsr got=%h/%b%b exp=81/00", result, c, z); end
  endtask

  task automatic test_logic_mov_nop;
    c_set = 1'b1; step(1'b1, 4'h5, 8'hF0, 8'h0F);
    checks++; if ({result, c, z} !== {8'h00, 2'b01}) begin failures++; $display("FAIL and_vs_cset got=%h/%b%b exp=00/01", result, c, z); end
    c_set = 1'b1; step(1'b1, 4'hF, 8'h12, 8'h34);
    checks++; if ({result, res_valid, c, z} !== {8'h00, 3'b111}) begin failures++; $display("FAIL nop_cset got=%h/%b exp=00/111", result, {res_valid, c, z}); end
    step(1'b1, 4'hE, 8'h00, 8'h5A);
    checks++; if ({result, c, z} !== {8'h5A, 2'b11}) begin failures++; $display("FAIL mov got=%h/%b%b exp=5a/11", result, c, z); end
    save = 1'b1; restore = 1'b1; step(1'b0, 4'hF, 8'h00, 8'h00);
    checks++; if ({c, z, shad_c, shad_z} !== 4'b0011) begin failures++; $display("FAIL save_and_restore got=%b exp=0011", {c, z, shad_c, shad_z}); end
  endtask

  task automatic test_reset_midstream;
    step(1'b1, 4'h0, 8'h7F, 8'h7F);
    rst = 1'b1; step(1'b1, 4'h0, 8'h01, 8'h01); rst = 1'b0;
    checks++; if ({result, res_valid, c, z, shad_c, shad_z} !== 13'd0) begin failures++; $display("FAIL mid_reset got=%h/%b exp=00/00000", result, {res_valid, c, z, shad_c, shad_z}); end
  endtask

  task automatic test_width16;
    op_valid16 = 1'b1; sel16 = 4'h0; a16 = 16'hFFFF; b16 = 16'h0001;
    @(posedge clk); #1; op_valid16 = 1'b0;
    checks++; if ({result16, res_valid16, c16, z16} !== {16'h0000, 3'b111}) begin failures++; $display("FAIL add16 got=%h/%b exp=0000/111", result16, {res_valid16, c16, z16}); end
    @(posedge clk); #1;
    checks++; if (res_valid16 !== 1'b0) begin failures++; $display("FAIL add16_rv_pulse got=%b exp=0", res_valid16); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_add();
    test_carry_chain();
    test_save_restore();
    test_shifts();
    test_logic_mov_nop();
    test_reset_midstream();
    test_width16();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
